// File: rtl/ariane_pkg.sv
// Minimal subset of the core package: control-flow types and the resolved-branch record
// consumed by the branch history table.
package ariane_pkg;

  typedef enum logic [2:0] {
    NoCF,
    Branch,
    Jump,
    JumpR,
    Return
  } cf_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
    logic        is_mispredict;
    logic        is_taken;
    cf_t         cf_type;
  } bp_resolve_t;

endpackage

// File: rtl/bht_resolve_unit_if.sv
// Bundle of the BHT resolve/lookup signals. The unit takes the slave side, the
// frontend/execute side drives the master side.
interface bht_resolve_unit_if;

  ariane_pkg::bp_resolve_t resolved_branch_i;
  logic                    debug_mode_i;
  logic                    flush_bp_i;
  logic [63:0]             vpc_i;
  logic                    bht_valid_o;
  logic                    bht_taken_o;
  logic                    ready_o;
  logic [31:0]             stat_branches_o;
  logic [31:0]             stat_mispredicts_o;

  modport master (
    output resolved_branch_i, debug_mode_i, flush_bp_i, vpc_i,
    input  bht_valid_o, bht_taken_o, ready_o, stat_branches_o, stat_mispredicts_o
  );

  modport slave (
    input  resolved_branch_i, debug_mode_i, flush_bp_i, vpc_i,
    output bht_valid_o, bht_taken_o, ready_o, stat_branches_o, stat_mispredicts_o
  );

endinterface

// File: rtl/bht_resolve_unit.sv
// Branch history table with 2-bit saturating counters, a one-entry-per-cycle flush sweep and
// a single-stage update register. Define BHT_STATS_EN to build the branch/mispredict counters.
module bht_resolve_unit #(
  parameter int unsigned NR_ENTRIES = 64
) (
  input logic               clk_i,
  input logic               rst_i,
  bht_resolve_unit_if.slave bp_if
);

  localparam int unsigned IdxW = $clog2(NR_ENTRIES);

  typedef logic [IdxW-1:0] idx_t;
  typedef enum logic {StFlush, StRun} state_e;

  state_e                state_q, state_d;
  idx_t                  sweep_q, sweep_d;
  logic                  upd_valid_q, upd_valid_d;
  idx_t                  upd_idx_q, upd_idx_d;
  logic [1:0]            upd_ctr_q, upd_ctr_d;
  logic [NR_ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]            ctr_q [NR_ENTRIES];
  logic [1:0]            ctr_d [NR_ENTRIES];

  logic       run, accept, wr_en, taken;
  idx_t       upd_idx, lkp_idx;
  logic       cur_valid;
  logic [1:0] cur_ctr;

  assign run     = (state_q == StRun);
  assign taken   = bp_if.resolved_branch_i.is_taken;
  assign upd_idx = bp_if.resolved_branch_i.pc[IdxW:1];
  assign lkp_idx = bp_if.vpc_i[IdxW:1];
  assign accept  = bp_if.resolved_branch_i.valid &&
                   (bp_if.resolved_branch_i.cf_type == ariane_pkg::Branch) &&
                   !bp_if.debug_mode_i && run && !bp_if.flush_bp_i;
  // A flush or reset in the write cycle discards the pending update.
  assign wr_en   = upd_valid_q && run && !bp_if.flush_bp_i && !rst_i;

  // New counter is computed at accept time; the pending write is bypassed in so that
  // back-to-back updates to one index chain correctly.
  always_comb begin
    cur_valid = valid_q[upd_idx];
    cur_ctr   = ctr_q[upd_idx];
    if (upd_valid_q && (upd_idx_q == upd_idx)) begin
      cur_valid = 1'b1;
      cur_ctr   = upd_ctr_q;
    end
    if (!cur_valid) begin
      upd_ctr_d = taken ? 2'b10 : 2'b01;
    end else if (taken) begin
      upd_ctr_d = (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'b01;
    end else begin
      upd_ctr_d = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'b01;
    end
    upd_valid_d = accept;
    upd_idx_d   = upd_idx;
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      StFlush: begin
        if (bp_if.flush_bp_i) begin
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + 1'b1;
          if (sweep_q == idx_t'(NR_ENTRIES - 1)) state_d = StRun;
        end
      end
      StRun: begin
        if (bp_if.flush_bp_i) begin
          state_d = StFlush;
          sweep_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    ctr_d   = ctr_q;
    if (!run) begin
      valid_d[sweep_q] = 1'b0;
    end else if (wr_en) begin
      valid_d[upd_idx_q] = 1'b1;
      ctr_d[upd_idx_q]   = upd_ctr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StFlush;
      sweep_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_ctr_q   <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      upd_valid_q <= upd_valid_d;
      upd_idx_q   <= upd_idx_d;
      upd_ctr_q   <= upd_ctr_d;
    end
  end

  // Table storage is not reset; valid bits are cleared by the sweep that follows reset.
  always_ff @(posedge clk_i) begin
    valid_q <= valid_d;
    ctr_q   <= ctr_d;
  end

  assign bp_if.ready_o     = run;
  assign bp_if.bht_valid_o = valid_q[lkp_idx] & run;
  assign bp_if.bht_taken_o = ctr_q[lkp_idx][1] & bp_if.bht_valid_o;

`ifdef BHT_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q + 32'(accept);
    stat_mp_d = stat_mp_q + 32'(accept && bp_if.resolved_branch_i.is_mispredict);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign bp_if.stat_branches_o    = stat_br_q;
  assign bp_if.stat_mispredicts_o = stat_mp_q;
`else
  assign bp_if.stat_branches_o    = '0;
  assign bp_if.stat_mispredicts_o = '0;

  logic unused_mispredict;
  assign unused_mispredict = bp_if.resolved_branch_i.is_mispredict;
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp_if.resolved_branch_i.pc[63:IdxW+1], bp_if.resolved_branch_i.pc[0],
                            bp_if.vpc_i[63:IdxW+1], bp_if.vpc_i[0]};

endmodule

// File: tb/tb_bht_resolve_unit.sv
// Scoreboard bench for bht_resolve_unit: stimulus queues expected values, a negedge monitor
// pops and compares them against the DUT outputs.
module tb_bht_resolve_unit;

  localparam int unsigned NR = 64;
  localparam int KLookup = 0;
  localparam int KReady  = 1;
  localparam int KBr     = 2;
  localparam int KMp     = 3;

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rst;
  logic chk_stb;
  int   n_checks;
  int   n_errors;
  int   exp_br;
  int   exp_mp;
  exp_t sb_q[$];

  bht_resolve_unit_if bp_if ();

  bht_resolve_unit #(
    .NR_ENTRIES(NR)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bp_if(bp_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    if (chk_stb) begin
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.kind)
          KLookup: act = {30'b0, bp_if.bht_valid_o, bp_if.bht_taken_o};
          KReady:  act = {31'b0, bp_if.ready_o};
          KBr:     act = bp_if.stat_branches_o;
          default: act = bp_if.stat_mispredicts_o;
        endcase
        n_checks++;
        if (act !== e.exp) begin
          n_errors++;
          $display("FAIL %s: got 0x%0h required 0x%0h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    chk_stb = 1'b0;
  endtask

  task automatic push(input string name, input int kind, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.exp  = val;
    sb_q.push_back(e);
    chk_stb = 1'b1;
  endtask

  // One lookup per cycle: vpc_i is shared by all lookups queued in a cycle.
  task automatic exp_lookup(input string name, input logic [63:0] pc, input logic v,
                            input logic t);
    bp_if.vpc_i = pc;
    push(name, KLookup, {30'b0, v, t});
  endtask

  task automatic exp_ready(input string name, input logic r);
    push(name, KReady, {31'b0, r});
  endtask

  task automatic exp_stats(input string tag);
`ifdef BHT_STATS_EN
    push({tag, "_stat_br"}, KBr, exp_br);
    push({tag, "_stat_mp"}, KMp, exp_mp);
`else
    push({tag, "_stat_br"}, KBr, 32'd0);
    push({tag, "_stat_mp"}, KMp, 32'd0);
`endif
  endtask

  task automatic set_upd(input logic [63:0] pc, input logic t, input logic mp,
                         input ariane_pkg::cf_t cf, input logic dbg, input logic acc);
    bp_if.resolved_branch_i.valid         = 1'b1;
    bp_if.resolved_branch_i.pc            = pc;
    bp_if.resolved_branch_i.is_taken      = t;
    bp_if.resolved_branch_i.is_mispredict = mp;
    bp_if.resolved_branch_i.cf_type       = cf;
    bp_if.debug_mode_i                    = dbg;
    if (acc) begin
      exp_br++;
      if (mp) exp_mp++;
    end
  endtask

  task automatic clr_upd();
    bp_if.resolved_branch_i.valid = 1'b0;
    bp_if.debug_mode_i            = 1'b0;
  endtask

  // Leaves the bench in cycle N+2, where the update just issued is visible.
  task automatic upd_wait(input logic [63:0] pc, input logic t, input logic mp,
                          input ariane_pkg::cf_t cf, input logic dbg, input logic acc);
    set_upd(pc, t, mp, cf, dbg, acc);
    tick();
    clr_upd();
    tick();
  endtask

  // Called in the first cycle after the reset/flush edge; ends in the first ready cycle.
  task automatic sweep_check(input string tag);
    for (int k = 1; k <= int'(NR); k++) begin
      if (k == 1) begin
        exp_ready({tag, "_ready_lo_first"}, 1'b0);
        exp_lookup({tag, "_valid_in_sweep"}, 64'h8000_0010, 1'b0, 1'b0);
      end
      if (k == int'(NR)) exp_ready({tag, "_ready_lo_last"}, 1'b0);
      tick();
    end
    exp_ready({tag, "_ready_hi"}, 1'b1);
  endtask

  task automatic flush_pulse(input string tag);
    bp_if.flush_bp_i = 1'b1;
    tick();
    bp_if.flush_bp_i = 1'b0;
    sweep_check(tag);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_br   = 0;
    exp_mp   = 0;
    chk_stb  = 1'b0;
    rst      = 1'b1;
    bp_if.resolved_branch_i = '0;
    bp_if.debug_mode_i      = 1'b0;
    bp_if.flush_bp_i        = 1'b0;
    bp_if.vpc_i             = '0;

    // Reset: two cycles high.
    tick();
    exp_ready("rst_ready_lo_during", 1'b0);
    tick();
    rst = 1'b0;
    sweep_check("rst");
    exp_lookup("rst_inv_0", 64'h0, 1'b0, 1'b0);
    exp_stats("rst");
    tick();
    exp_lookup("rst_inv_a", 64'h8000_0010, 1'b0, 1'b0);
    tick();
    exp_lookup("rst_inv_7e", 64'h7e, 1'b0, 1'b0);
    tick();

    // Training at index 8: 10, 11, 11, then not-taken 10, then 01.
    upd_wait(64'h8000_0010, 1'b1, 1'b1, ariane_pkg::Branch, 1'b0, 1'b1);
    exp_lookup("train_t1", 64'h8000_0010, 1'b1, 1'b1);
    tick();
    upd_wait(64'h8000_0010, 1'b1, 1'b0, ariane_pkg::Branch, 1'b0, 1'b1);
    exp_lookup("train_t2", 64'h8000_0010, 1'b1, 1'b1);
    tick();
    upd_wait(64'h8000_0010, 1'b1, 1'b0, ariane_pkg::Branch, 1'b0, 1'b1);
    exp_lookup("train_t3", 64'h8000_0010, 1'b1, 1'b1);
    tick();
    upd_wait(64'h8000_0010, 1'b0, 1'b1, ariane_pkg::Branch, 1'b0, 1'b1);
    exp_lookup("train_nt1", 64'h8000_0010, 1'b1, 1'b1);
    tick();
    upd_wait(64'h8000_0010, 1'b0, 1'b0, ariane_pkg::Branch, 1'b0, 1'b1);
    exp_lookup("train_nt2", 64'h8000_0010, 1'b1, 1'b0);
    exp_stats("train");
    tick();

    flush_pulse("flush1");
    exp_lookup("flush1_inv_a", 64'h8000_0010, 1'b0, 1'b0);
    exp_stats("flush1");
    tick();

    // Back-to-back taken updates to an invalid entry at 0x100.
    set_upd(64'h100, 1'b1, 1'b0, ariane_pkg::Branch, 1'b0, 1'b1);
    tick();
    set_upd(64'h100, 1'b1, 1'b0, ariane_pkg::Branch, 1'b0, 1'b1);
    exp_lookup("byp_n1", 64'h100, 1'b0, 1'b0);
    tick();
    clr_upd();
    exp_lookup("byp_n2", 64'h100, 1'b1, 1'b1);
    tick();
    exp_lookup("byp_n3", 64'h100, 1'b1, 1'b1);
    tick();
    // From 11 one not-taken stays taken; a lost update (10) would drop to 01.
    upd_wait(64'h100, 1'b0, 1'b0, ariane_pkg::Branch, 1'b0, 1'b1);
    exp_lookup("byp_after_nt", 64'h100, 1'b1, 1'b1);
    tick();

    flush_pulse("flush2");

    // Filtering: JumpR and debug-mode updates are ignored.
    upd_wait(64'h200, 1'b1, 1'b1, ariane_pkg::JumpR, 1'b0, 1'b0);
    upd_wait(64'h200, 1'b1, 1'b1, ariane_pkg::Branch, 1'b1, 1'b0);
    exp_lookup("filt_inv", 64'h200, 1'b0, 1'b0);
    exp_stats("filt");
    tick();

    // Flush collides with a taken update.
    set_upd(64'h300, 1'b1, 1'b0, ariane_pkg::Branch, 1'b0, 1'b0);
    bp_if.flush_bp_i = 1'b1;
    tick();
    clr_upd();
    bp_if.flush_bp_i = 1'b0;
    sweep_check("col");
    exp_lookup("col_inv", 64'h300, 1'b0, 1'b0);
    exp_stats("col");
    tick();

    // Flush seen mid-sweep restarts the full sweep.
    bp_if.flush_bp_i = 1'b1;
    tick();
    bp_if.flush_bp_i = 1'b0;
    repeat (10) tick();
    bp_if.flush_bp_i = 1'b1;
    tick();
    bp_if.flush_bp_i = 1'b0;
    sweep_check("restart");
    tick();

    @(negedge clk);
    #1;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bht_resolve_unit.md
BHT_RESOLVE_UNIT -- requirements
Module: bht_resolve_unit

Interface
REQ-001 SHALL have parameter NR_ENTRIES, default 64, meaning number of BHT entries (power of two, 16..1024).
REQ-002 SHALL have port clk_i, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port debug_mode_i, input, 1, core in debug mode; suppresses training.
REQ-005 SHALL have port flush_bp_i, input, 1, request to invalidate the whole table.
REQ-006 SHALL have port resolved_branch_i, input, ariane_pkg::bp_resolve_t, resolved control-flow result from the execute stage.
- Fields used: valid, pc, is_taken, is_mispredict, cf_type.
REQ-007 SHALL have port vpc_i, input, 64, fetch PC to look up.
REQ-008 SHALL have port bht_valid_o, input-dependent output, 1, looked-up entry holds trained state.
REQ-009 SHALL have port bht_taken_o, output, 1, predicted direction.
REQ-010 SHALL have port ready_o, output, 1, unit is out of flush sweep.
REQ-011 SHALL have port stat_branches_o, output, 32, count of accepted branch updates.
REQ-012 SHALL have port stat_mispredicts_o, output, 32, count of accepted mispredicted branch updates.

Function
REQ-013 SHALL index the table with pc[log2(NR_ENTRIES):1]; bit 0 is ignored (for example, pc 0x8000_0010 with 64 entries gives index 8).
REQ-014 SHALL store per entry a valid bit and a 2-bit counter with the following encoding:
- 00: strong not-taken.
- 01: weak not-taken.
- 10: weak taken.
- 11: strong taken.
REQ-015 SHALL accept an update only when all of the following hold:
- resolved_branch_i.valid=1.
- cf_type==ariane_pkg::Branch.
- debug_mode_i=0.
- FSM is in RUN.
- flush_bp_i=0.
REQ-016 SHALL register an accepted update (index, is_taken) in a single-stage update register in cycle N and write the table at the end of cycle N+1.
- The result is visible to lookups from cycle N+2.
REQ-017 SHALL write an entry that was invalid before the update as follows:
- Counter set to 10 if taken, 01 if not taken.
- Valid bit set.
REQ-018 SHALL update an entry that was already valid as follows:
- Taken: counter increments, saturating at 11.
- Not taken: counter decrements, saturating at 00.
REQ-019 SHALL serve two accepted updates in consecutive cycles to the same index back to back, with the second computed from the first's written value (no lost update).
- Implementation: bypass from the update register.
REQ-020 SHALL compute lookup combinationally from vpc_i and table state as follows:
- bht_valid_o = entry valid AND ready_o.
- bht_taken_o = counter[1] AND bht_valid_o.
REQ-021 SHALL implement an FSM with states FLUSH and RUN:
- FLUSH clears one entry's valid bit per cycle, with the sweep index running 0..NR_ENTRIES-1.
- FLUSH moves to RUN after the last entry is cleared.
- ready_o=1 only in RUN.
REQ-022 SHALL make flush_bp_i=1 in RUN enter FLUSH on the next cycle with the sweep index set to 0.
- The pending update register is discarded.
REQ-023 SHALL give flush_bp_i priority over an update presented in the same cycle; that update is dropped.
REQ-024 SHALL restart the sweep from index 0 when flush_bp_i=1 is seen during FLUSH.
REQ-025 SHALL increment stat_branches_o on each accepted update, and stat_mispredicts_o on each accepted update with is_mispredict=1.
- Both counters wrap modulo 2^32.
- Neither counter is cleared by flush_bp_i.

Reset
REQ-026 SHALL, while rst_i=1 at a clock edge, do all of the following:
- Put the FSM in FLUSH with sweep index 0.
- Clear the update register.
- Zero both stat counters.
REQ-027 SHALL leave counter contents undefined after reset; valid bits are cleared only by the sweep.
REQ-028 SHALL take ready_o low in the cycle after rst_i is sampled high, and return it high exactly NR_ENTRIES cycles after rst_i deasserts.
REQ-029 SHALL restart the sweep from index 0 when reset is asserted mid-sweep or mid-update, and discard any pending update.

Configuration
REQ-030 SHALL implement the stat counters of REQ-025 only when macro BHT_STATS_EN is defined.
- When it is undefined, stat_branches_o and stat_mispredicts_o SHALL be constant 0 and no counter flops exist.
- All other behaviour is identical with and without the macro.

Verification
REQ-031 SHALL cover reset: rst_i high 2 cycles then low -> ready_o=0 for 64 cycles, then 1; bht_valid_o=0 for every vpc_i.
REQ-032 SHALL cover training: 3 taken branch updates at pc 0x8000_0010 -> counter sequence 10, 11, 11; lookup of vpc_i 0x8000_0010 gives valid=1, taken=1. A not-taken update then gives 10, taken=1.
REQ-033 SHALL cover latency/bypass: taken updates in cycles N and N+1 at pc 0x100 on an invalid entry -> counter 11 visible at cycle N+3. Lookup at cycle N+1 gives valid=0.
REQ-034 SHALL cover filtering: updates with cf_type=JumpR, or with debug_mode_i=1, at pc 0x200 -> entry stays invalid and stats unchanged.
REQ-035 SHALL cover flush collision: flush_bp_i pulsed in the same cycle as a taken update at pc 0x300 -> update dropped, ready_o low 64 cycles, entry invalid afterwards, stat_branches_o unchanged.
REQ-036 SHALL cover stats: with BHT_STATS_EN, 5 accepted updates of which 2 have is_mispredict=1 -> stat_branches_o=5, stat_mispredicts_o=2. Without the macro, both stay 0.
